// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM state encoding,
// AXI response codes and the fixed protection value.
package axi4lite_pkg;

   // FSM states are plain constants so legacy tools and waveform viewers see raw codes
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WR_REQ  = 3'd1;
   localparam state_t ST_WR_RESP = 3'd2;
   localparam state_t ST_RD_REQ  = 3'd3;
   localparam state_t ST_RD_RESP = 3'd4;
   localparam state_t ST_RSP     = 3'd5;

   // AXI response encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Unprivileged, secure, data access
   localparam logic [2:0] AXI_PROT = 3'b000;

   // True for the states in which the master is waiting on the slave
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
             (s == ST_RD_REQ) || (s == ST_RD_RESP);
   endfunction

endpackage

// File: rtl/axi4lite_timeout_cnt.sv
// Clear/enable counter that flags expiry once it has counted TIMEOUT cycles.
// TIMEOUT = 0 disables expiry entirely.
module axi4lite_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic aclk,
   input  logic areset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Count enabled cycles, saturating at the limit so a phase change that does
   // not clear the counter cannot wrap it past the expiry point
   always_ff @(posedge aclk) begin
      if (areset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_disabled
         assign expire = 1'b0;
      end else begin : g_enabled
         assign expire = (count == LIMIT);
      end
   endgenerate

endmodule

// File: rtl/axi4lite_cmd_master.sv
// Converts a simple command/response stream into single outstanding AXI4-Lite
// write or read transactions, with a per-transaction timeout guarding against
// a slave that never answers.
module axi4lite_cmd_master
   import axi4lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    aclk,
   input  logic                    areset,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,

   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,

   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,

   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp,

   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [2:0]              arprot,

   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp
);

   state_t state;
   logic   stale_b;
   logic   stale_r;

   logic   accept;
   logic   aw_hs;
   logic   w_hs;
   logic   ar_hs;
   logic   b_hs;
   logic   r_hs;
   logic   wr_addr_done;
   logic   wr_data_done;
   logic   cnt_clear;
   logic   expire;
   logic   abort;
   logic   abort_write;
   logic   abort_read;

   assign cmd_ready = (state == ST_IDLE) && !stale_b && !stale_r;
   assign accept    = cmd_valid && cmd_ready;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;
   assign b_hs  = bvalid && bready;
   assign r_hs  = rvalid && rready;

   // A write channel is finished once its valid has dropped or is handshaking now
   assign wr_addr_done = !awvalid || awready;
   assign wr_data_done = !wvalid || wready;

   // A stale flag keeps the ready high so the late answer of an aborted transfer is swallowed
   assign bready = (state == ST_WR_RESP) || stale_b;
   assign rready = (state == ST_RD_RESP) || stale_r;

   assign rsp_valid = (state == ST_RSP);

   assign awprot = AXI_PROT;
   assign arprot = AXI_PROT;

   // Restart the budget on every new command and on every write-side partial handshake
   assign cnt_clear = accept || ((state == ST_WR_REQ) && (aw_hs || w_hs));

   axi4lite_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .aclk    (aclk),
      .areset  (areset),
      .clear   (cnt_clear),
      .enable  (is_wait_state(state)),
      .expire  (expire)
   );

   // Abort only when the timer expires without the awaited handshake in the same cycle
   always_comb begin
      abort = 1'b0;
      case (state)
         ST_WR_REQ:  abort = expire && !aw_hs && !w_hs;
         ST_WR_RESP: abort = expire && !bvalid;
         ST_RD_REQ:  abort = expire && !ar_hs;
         ST_RD_RESP: abort = expire && !rvalid;
         default:    abort = 1'b0;
      endcase
   end

   assign abort_write = abort && ((state == ST_WR_REQ) || (state == ST_WR_RESP));
   assign abort_read  = abort && ((state == ST_RD_REQ) || (state == ST_RD_RESP));

   // Transaction sequencing and capture of the response presented upstream
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= ST_IDLE;
         rsp_rdata   <= '0;
         rsp_resp    <= RESP_OKAY;
         rsp_timeout <= 1'b0;
      end else if (abort) begin
         state       <= ST_RSP;
         rsp_rdata   <= '0;
         rsp_resp    <= RESP_OKAY;
         rsp_timeout <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= cmd_write ? ST_WR_REQ : ST_RD_REQ;
               end
            end
            ST_WR_REQ: begin
               if (wr_addr_done && wr_data_done) begin
                  state <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (b_hs) begin
                  state       <= ST_RSP;
                  rsp_rdata   <= '0;
                  rsp_resp    <= bresp;
                  rsp_timeout <= 1'b0;
               end
            end
            ST_RD_REQ: begin
               if (ar_hs) begin
                  state <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (r_hs) begin
                  state       <= ST_RSP;
                  rsp_rdata   <= rdata;
                  rsp_resp    <= rresp;
                  rsp_timeout <= 1'b0;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // AXI request channels: each valid rises on accept and falls only after its own handshake,
   // independent of the FSM so an abort never withdraws a valid early
   always_ff @(posedge aclk) begin
      if (areset) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         arvalid <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         araddr  <= '0;
      end else begin
         if (accept && cmd_write) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= cmd_addr;
            wdata   <= cmd_wdata;
            wstrb   <= cmd_wstrb;
         end else begin
            if (awready) begin
               awvalid <= 1'b0;
            end
            if (wready) begin
               wvalid <= 1'b0;
            end
         end
         if (accept && !cmd_write) begin
            arvalid <= 1'b1;
            araddr  <= cmd_addr;
         end else if (arready) begin
            arvalid <= 1'b0;
         end
      end
   end

   // Remember an aborted transfer until its late response has been drained
   always_ff @(posedge aclk) begin
      if (areset) begin
         stale_b <= 1'b0;
         stale_r <= 1'b0;
      end else begin
         if (abort_write) begin
            stale_b <= 1'b1;
         end else if (stale_b && bvalid) begin
            stale_b <= 1'b0;
         end
         if (abort_read) begin
            stale_r <= 1'b1;
         end else if (stale_r && rvalid) begin
            stale_r <= 1'b0;
         end
      end
   end

endmodule
